// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op and sequencer state encodings
// Purpose: constants shared by the ALU and the alu_arbiter sequencer.
// Ports: none (package).
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU (add, sub, and, xor) with signed overflow
// Purpose: single shared ALU evaluated on the sequencer's latched operands.
// Ports:
//   out      result, wraps modulo 2^WIDTH
//   overflow signed overflow for add/sub, 0 for and/xor
//   a, b     operands
//   control  op select (ALU_ADD/ALU_SUB/ALU_AND/ALU_XOR)
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       control
);

  always_comb begin
    out      = '0;
    overflow = 1'b0;
    case (control)
      ALU_ADD: begin
        out      = a + b;
        // Same-sign operands producing a result of the other sign.
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (out[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        out      = a - b;
        // Opposite-sign operands where the result sign departs from a.
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (out[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: out = a & b;
      ALU_XOR: out = a ^ b;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sequencer sharing one ALU among N requesters
// Purpose: grants one requester at a time (IDLE), runs the latched op (EXEC),
//          holds the registered result until accepted (DONE).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester handshake, req_ready one-hot
//   req_a, req_b         packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op, req_setcc    packed op codes (2 bits each), CC update enables
//   res_valid/res_ready  result handshake
//   res_data, res_ovf    registered result and signed overflow
//   res_id               requester that issued the result
//   cc_zf, cc_sf, cc_of  condition codes, present only with ALU_ARB_CC_EN
// Config macro: ALU_ARB_CC_EN enables the condition-code register and ports.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N     = 2,
  parameter int ID_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*WIDTH-1:0] req_a,
  input  logic [N*WIDTH-1:0] req_b,
  input  logic [N*2-1:0]   req_op,
  input  logic [N-1:0]     req_setcc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic [ID_W-1:0]  res_id
`ifdef ALU_ARB_CC_EN
  ,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
`endif
);

  logic [1:0]       state;
  logic [ID_W-1:0]  last_grant;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;
  logic [1:0]       lat_op;
  logic [ID_W-1:0]  lat_id;
  logic [WIDTH-1:0] alu_out;
  logic             alu_ovf;
  logic [ID_W:0]    pick;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;

  // Returns {found, index}: the first set bit at offsets 1..N above last.
  // Iterating from the farthest offset down lets the nearest one win.
  function automatic logic [ID_W:0] rr_pick(input logic [N-1:0] v,
                                            input logic [ID_W-1:0] last);
    logic [ID_W:0] r;
    int            idx;
    r = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (v[idx]) r = {1'b1, ID_W'(idx)};
    end
    return r;
  endfunction

  always_comb begin
    pick        = rr_pick(req_valid, last_grant);
    grant_valid = pick[ID_W];
    grant_id    = pick[ID_W-1:0];
  end

  always_comb begin
    req_ready = '0;
    if ((state == ST_IDLE) && !rst && grant_valid) req_ready[grant_id] = 1'b1;
  end

  assign res_valid = (state == ST_DONE);

  alu #(.WIDTH(WIDTH)) u_alu (
    .out      (alu_out),
    .overflow (alu_ovf),
    .a        (lat_a),
    .b        (lat_b),
    .control  (lat_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= ID_W'(N - 1);
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= ALU_ADD;
      lat_id     <= '0;
      res_data   <= '0;
      res_ovf    <= 1'b0;
      res_id     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            lat_a      <= req_a[int'(grant_id)*WIDTH +: WIDTH];
            lat_b      <= req_b[int'(grant_id)*WIDTH +: WIDTH];
            lat_op     <= req_op[int'(grant_id)*2 +: 2];
            lat_id     <= grant_id;
            last_grant <= grant_id;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_data <= alu_out;
          res_ovf  <= alu_ovf;
          res_id   <= lat_id;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_CC_EN
  logic lat_setcc;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_setcc <= 1'b0;
      cc_zf     <= 1'b1;
      cc_sf     <= 1'b0;
      cc_of     <= 1'b0;
    end else if ((state == ST_IDLE) && grant_valid) begin
      lat_setcc <= req_setcc[grant_id];
    end else if ((state == ST_EXEC) && lat_setcc) begin
      cc_zf <= (alu_out == '0);
      cc_sf <= alu_out[WIDTH-1];
      cc_of <= alu_ovf;
    end
  end
`else
  // Without condition codes the per-request setcc flag has no effect.
  logic unused_setcc;
  assign unused_setcc = ^req_setcc;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam int WIDTH = 64;
  localparam int N     = 2;
  localparam int ID_W  = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*WIDTH-1:0] req_a;
  logic [N*WIDTH-1:0] req_b;
  logic [N*2-1:0]     req_op;
  logic [N-1:0]       req_setcc;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH-1:0]   res_data;
  logic               res_ovf;
  logic [ID_W-1:0]    res_id;
`ifdef ALU_ARB_CC_EN
  logic               cc_zf, cc_sf, cc_of;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_setcc (req_setcc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .res_id    (res_id)
`ifdef ALU_ARB_CC_EN
    ,
    .cc_zf     (cc_zf),
    .cc_sf     (cc_sf),
    .cc_of     (cc_of)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] op, input logic setcc);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_op[id*2 +: 2]        = op;
    req_setcc[id]            = setcc;
    req_valid[id]            = 1'b1;
  endtask

  task automatic check_cc(input string tag, input logic zf, input logic sf, input logic of_);
`ifdef ALU_ARB_CC_EN
    check({tag, "_zf"}, 64'(cc_zf), 64'(zf));
    check({tag, "_sf"}, 64'(cc_sf), 64'(sf));
    check({tag, "_of"}, 64'(cc_of), 64'(of_));
`else
    if (zf === 1'bx || sf === 1'bx || of_ === 1'bx) $display("cc %s not present", tag);
`endif
  endtask

  // Runs one single-requester op from IDLE through DONE and checks timing.
  task automatic single_op(input string tag, input int id, input logic [63:0] a,
                           input logic [63:0] b, input logic [1:0] op, input logic setcc,
                           input logic [63:0] exp_data, input logic exp_ovf);
    set_req(id, a, b, op, setcc);
    #1;
    check({tag, "_grant"}, 64'(req_ready), 64'(1 << id));
    step();
    req_valid[id] = 1'b0;
    #1;
    check({tag, "_exec_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_exec_valid"}, 64'(res_valid), 64'd0);
    step();
    check({tag, "_valid"}, 64'(res_valid), 64'd1);
    check({tag, "_data"}, res_data, exp_data);
    check({tag, "_ovf"}, 64'(res_ovf), 64'(exp_ovf));
    check({tag, "_id"}, 64'(res_id), 64'(id));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    req_setcc = '0;
    res_ready = 1'b1;
    step();
    req_valid = 2'b11;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    step();
    rst = 1'b0;
    #1;
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_data", res_data, 64'd0);
    check("rst_ovf", 64'(res_ovf), 64'd0);
    check("rst_id", 64'(res_id), 64'd0);
    check_cc("rst_cc", 1'b1, 1'b0, 1'b0);

    single_op("add", 0, 64'd11, 64'd4, 2'b00, 1'b0, 64'd15, 1'b0);
    step();
    single_op("subovf", 0, 64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFD, 2'b01, 1'b1,
              64'h8000000000000002, 1'b1);
    check_cc("subovf_cc", 1'b0, 1'b1, 1'b1);
    step();
    single_op("and0", 0, 64'd11, 64'd4, 2'b10, 1'b1, 64'd0, 1'b0);
    check_cc("and0_cc", 1'b1, 1'b0, 1'b0);
    step();
    single_op("xor", 0, 64'd11, 64'd4, 2'b11, 1'b0, 64'd15, 1'b0);
    check_cc("xor_cc_kept", 1'b1, 1'b0, 1'b0);
    step();

    // Fairness: both held after reset alternate starting at requester 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 64'd100, 64'd1, 2'b00, 1'b0);
    set_req(1, 64'd200, 64'd1, 2'b01, 1'b0);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fair%0d_grant", i), 64'(req_ready), 64'(1 << (i % 2)));
      step();
      check($sformatf("fair%0d_exec", i), 64'(req_ready), 64'd0);
      step();
      check($sformatf("fair%0d_done_ready", i), 64'(req_ready), 64'd0);
      check($sformatf("fair%0d_id", i), 64'(res_id), 64'(i % 2));
      check($sformatf("fair%0d_data", i), res_data, (i % 2 == 0) ? 64'd101 : 64'd199);
      if (i == 3) req_valid = '0;
      step();
    end

    // Backpressure: requester 0 wins (last grant was 1); 1 waits through DONE.
    res_ready = 1'b0;
    set_req(0, 64'd10, 64'd3, 2'b01, 1'b1);
    set_req(1, 64'hF0, 64'hFF, 2'b11, 1'b0);
    #1;
    check("bp_grant", 64'(req_ready), 64'd1);
    step();
    req_valid[0] = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_valid", i), 64'(res_valid), 64'd1);
      check($sformatf("bp%0d_data", i), res_data, 64'd7);
      check($sformatf("bp%0d_id", i), 64'(res_id), 64'd0);
      check($sformatf("bp%0d_ready", i), 64'(req_ready), 64'd0);
      if (i < 4) step();
    end
    res_ready = 1'b1;
    #1;
    check("bp_accept_valid", 64'(res_valid), 64'd1);
    step();
    check("bp_next_grant", 64'(req_ready), 64'd2);
    step();
    req_valid[1] = 1'b0;
    step();
    check("bp_r1_data", res_data, 64'h0F);
    check("bp_r1_id", 64'(res_id), 64'd1);
    check_cc("bp_cc", 1'b0, 1'b0, 1'b0);
    step();

    // Reset during EXEC discards the op; requester 0 wins first afterwards.
    set_req(0, 64'd1, 64'd1, 2'b00, 1'b1);
    set_req(1, 64'd6, 64'd3, 2'b10, 1'b0);
    #1;
    check("mid_grant", 64'(req_ready), 64'd1);
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("mid_valid", 64'(res_valid), 64'd0);
    check("mid_data", res_data, 64'd0);
    check("mid_id", 64'(res_id), 64'd0);
    check_cc("mid_cc", 1'b1, 1'b0, 1'b0);
    check("mid_regrant", 64'(req_ready), 64'd1);
    step();
    req_valid[0] = 1'b0;
    step();
    check("mid_r0_data", res_data, 64'd2);
    check("mid_r0_id", 64'(res_id), 64'd0);
    step();
    check("mid_r1_grant", 64'(req_ready), 64'd2);
    step();
    req_valid[1] = 1'b0;
    step();
    check("mid_r1_data", res_data, 64'd2);
    check("mid_r1_id", 64'(res_id), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and round-robin arbiter that shares the single 64-bit ALU (ops: add, sub, and, xor; signed overflow flag) among N requesting pipeline units. It accepts one operation at a time over a valid/ready handshake, latches the operands, runs them through the ALU, and holds a registered result until the consumer accepts it. It optionally maintains the Y86-style condition-code register (ZF/SF/OF) fed by ALU results.

## Interface
- WIDTH, 64: operand/result width.
- N, 2: number of requesters (2..8).
- ID_W, $clog2(N) (min 1): requester-id width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N  per-requester request.
- req_ready  out  N  one-hot grant/accept, at most one bit high.
- req_a  in  N*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  N*WIDTH  operand B, same packing.
- req_op  in  N*2  op per requester: 00 add, 01 sub (a-b), 10 and, 11 xor.
- req_setcc  in  N  update condition codes with this op.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  ALU result.
- res_ovf  out  1  signed overflow (add/sub only; 0 for and/xor).
- res_id  out  ID_W  index of the requester that issued the op.
- cc_zf, cc_sf, cc_of  out  1 each  condition codes (only with ALU_ARB_CC_EN).

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: if any req_valid is set, grant the first set bit searching upward from (last_grant+1) mod N with wrap-around. req_ready[g] is asserted combinationally in the same cycle. On that edge: latch a, b, op, setcc, id; set last_grant=g; go to EXEC. With no request, stay in IDLE.
- EXEC: the ALU evaluates the latched operands. On the edge, capture out/overflow into res_data/res_ovf; if setcc, update the CCs; go to DONE.
- DONE: res_valid=1, outputs stable. On res_valid&&res_ready go to IDLE. Otherwise hold indefinitely (backpressure).
- req_ready is 0 in EXEC and DONE. Requests from other units are neither lost nor acknowledged; the requester holds valid.
- Arithmetic: wrap-around modulo 2^WIDTH, two's complement.
  - Add: ovf = a,b same sign and result sign differs.
  - Sub: ovf = a,b differ in sign and result sign differs from a.
- CC update: zf = (result==0), sf = result[WIDTH-1], of = ovf.

## Timing
- Grant in cycle t; res_valid asserted from cycle t+2; earliest next grant at t+3 if res_ready is high at t+2. Peak throughput is 1 op / 3 cycles.
- CCs are visible from cycle t+2, i.e. together with res_valid.
- Reset (any state, including mid-operation): state=IDLE; res_valid=0, res_data=0, res_ovf=0, res_id=0; req_ready=0 during the reset cycle; last_grant=N-1, so requester 0 wins first; cc_zf=1, cc_sf=0, cc_of=0. An in-flight op is discarded and not retried.
- req_valid dropping in IDLE before a grant is legal; nothing is latched.

## Configuration
- ALU_ARB_CC_EN defined: the CC register and the cc_* ports exist, updated as above when setcc=1.
- Undefined: no CC flops and no cc_* ports. req_setcc is still present but ignored.

## Structure
- Shared package alu_pkg: ALU op encodings (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_XOR=2'b11) and the FSM state encodings.
- One sub-module: the existing combinational ALU (out, overflow, a, b, control), instantiated once on the latched operands.
- The round-robin pick is a local function, not a separate module.

## Test plan
- Single add, req 0: a=11, b=4, op=00 -> res_data=15, res_ovf=0, res_id=0, res_valid exactly 2 cycles after grant.
- Sub overflow: a=0x7FFFFFFFFFFFFFFF, b=0xFFFFFFFFFFFFFFFD (-3), op=01, setcc=1 -> res_data=0x8000000000000002, res_ovf=1; with CC_EN: sf=1, of=1, zf=0.
- Logic and zero: a=11, b=4, op=10 -> res_data=0, ovf=0, with setcc zf=1; then op=11 -> res_data=15.
- Fairness: req 0 and 1 held valid continuously after reset -> grants alternate 0,1,0,1; res_id follows the same order; no grant while in EXEC/DONE.
- Backpressure: res_ready=0 for 5 cycles -> res_valid, res_data, res_id stable, req_ready=0 throughout; accepted on the cycle res_ready rises, and the next grant follows the cycle after.
- Reset mid-op: assert rst during EXEC -> the next cycle shows res_valid=0, IDLE, CCs at reset values; a held req 1 alongside req 0 then receives grant 0 first.
